// File: rtl/hgcal_input_packer_pkg.sv
// ============================================================================
// hgcal_pkg : shared constants, packer state encoding and width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package hgcal_pkg;

  localparam int HGCAL_N_FEAT = 48;
  localparam int HGCAL_IN_W   = 8;
  localparam int HGCAL_Q_BITS = 2;
  localparam int HGCAL_SHIFT  = 6;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_e;

  function automatic int packed_width(input int n_feat, input int q_bits);
    return n_feat * q_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hgcal_feat_quant.sv
// ============================================================================
// hgcal_feat_quant : combinational shift-then-saturate quantizer, IN_W -> Q_BITS
// Rev 1.0
// ============================================================================
`default_nettype none

module hgcal_feat_quant #(
  parameter int IN_W   = 8,
  parameter int Q_BITS = 2,
  parameter int SHIFT  = 6
) (
  input  logic [IN_W-1:0]   sample_i,
  output logic [Q_BITS-1:0] code_o
);

  localparam logic [IN_W-1:0] SAT = IN_W'((1 << Q_BITS) - 1);

  logic [IN_W-1:0] shifted;

  assign shifted = sample_i >> SHIFT;
  assign code_o  = (shifted > SAT) ? SAT[Q_BITS-1:0] : shifted[Q_BITS-1:0];

endmodule

`default_nettype wire

// File: rtl/hgcal_input_packer.sv
// ============================================================================
// hgcal_input_packer : double-buffered sample-to-frame packer for layer0.
// Optional statistics counters enabled by HGCAL_PACKER_STATS_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module hgcal_input_packer
  import hgcal_pkg::*;
#(
  parameter int N_FEAT = HGCAL_N_FEAT,
  parameter int IN_W   = HGCAL_IN_W,
  parameter int Q_BITS = HGCAL_Q_BITS,
  parameter int SHIFT  = HGCAL_SHIFT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [IN_W-1:0]                   s_data,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [packed_width(N_FEAT, Q_BITS)-1:0] m_data,
  output logic                              frame_err
`ifdef HGCAL_PACKER_STATS_EN
  ,
  output logic [15:0]                       frame_cnt,
  output logic [15:0]                       err_cnt
`endif
);

  localparam int DATA_W = packed_width(N_FEAT, Q_BITS);
  localparam int IDX_W  = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);

  packer_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              s_ready_q;
  logic              frame_err_q, frame_err_d;

  logic              accept;
  logic              slot_free;
  logic              at_last_idx;
  logic              close;
  logic              misplaced;
  logic [Q_BITS-1:0] code;
  logic [DATA_W-1:0] asm_fill;

  hgcal_feat_quant #(
    .IN_W   (IN_W),
    .Q_BITS (Q_BITS),
    .SHIFT  (SHIFT)
  ) u_quant (
    .sample_i (s_data),
    .code_o   (code)
  );

  assign accept      = s_valid && s_ready_q;
  assign slot_free   = !m_valid_q || m_ready;
  assign at_last_idx = (idx_q == IDX_LAST);
  assign close       = accept && (s_last || at_last_idx);
  // A frame is malformed whenever the closing beat and s_last disagree.
  assign misplaced   = close && (s_last != at_last_idx);

  always_comb begin
    asm_fill = asm_q;
    if (accept) begin
      asm_fill[idx_q*Q_BITS +: Q_BITS] = code;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q && !m_ready;
    frame_err_d = frame_err_q || misplaced;
    case (state_q)
      FILL: begin
        if (accept) begin
          if (close) begin
            idx_d = '0;
            if (slot_free) begin
              m_data_d  = asm_fill;
              m_valid_d = 1'b1;
              asm_d     = '0;
            end else begin
              asm_d   = asm_fill;
              state_d = HOLD;
            end
          end else begin
            asm_d = asm_fill;
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          m_data_d  = asm_q;
          m_valid_d = 1'b1;
          asm_d     = '0;
          state_d   = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= (state_d == FILL);
      frame_err_q <= frame_err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign frame_err = frame_err_q;

`ifdef HGCAL_PACKER_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (m_valid_q && m_ready) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (misplaced)            err_cnt_q   <= err_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_hgcal_input_packer.sv
// ============================================================================
// tb_hgcal_input_packer : directed self-checking bench for hgcal_input_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_hgcal_input_packer;

  localparam int N  = 48;
  localparam int DW = 96;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [7:0]    s_data = 8'h00;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          frame_err;
`ifdef HGCAL_PACKER_STATS_EN
  logic [15:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  logic [7:0]    smp [0:127];

  hgcal_input_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .frame_err (frame_err)
`ifdef HGCAL_PACKER_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake happens at the following rising edge; values are stable here.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [1:0] quant(input logic [7:0] x);
    logic [7:0] t;
    t = x >> 6;
    return (t > 8'd3) ? 2'd3 : t[1:0];
  endfunction

  function automatic logic [DW-1:0] expect_frame(input int start, input int count);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < count; k++) v[k*2 +: 2] = quant(smp[start+k]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_smp(input int seed);
    for (int i = 0; i < 128; i++) smp[i] = 8'(i * 37 + seed * 91 + 13) ^ 8'(i * 5);
  endtask

  task automatic send_range(input int first, input int last_idx, input int last_at);
    for (int i = first; i <= last_idx; i++) begin
      int waitc;
      waitc   = 0;
      s_valid = 1'b1;
      s_data  = smp[i];
      s_last  = (i == last_at);
      while (!s_ready && waitc < 500) begin
        tick();
        waitc++;
      end
      if (waitc >= 500) begin
        checks++;
        failures++;
        $display("FAIL send_timeout beat=%0d s_ready=%b want=1", i, s_ready);
      end
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 300) begin
      tick();
      c++;
    end
    checks++;
    if (got_q.size() != n) begin
      failures++;
      $display("FAIL frame_count got=%0d want=%0d", got_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL rst_m_data got=%h want=0", m_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rst_frame_err got=%b want=0", frame_err); end
    rst = 1'b1;
    tick();
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rst_s_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] exp_v;
    exp_v = '0;
    for (int i = 0; i < N; i++) begin
      case (i % 4)
        0: smp[i] = 8'h00;
        1: smp[i] = 8'h40;
        2: smp[i] = 8'h80;
        default: smp[i] = 8'hFF;
      endcase
      exp_v[i*2 +: 2] = 2'(i % 4);
    end
    m_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    send_range(0, 46, -1);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b want=0", m_valid); end
    send_range(47, 47, 47);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b want=1", m_valid); end
    checks++; if (m_data !== exp_v) begin failures++; $display("FAIL basic_data got=%h want=%h", m_data, exp_v); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL basic_frame_err got=%b want=0", frame_err); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_drop got=%b want=0", m_valid); end
    wait_frames(1);
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_a, exp_b;
    logic          stable;
    fill_smp(1);
    exp_a = expect_frame(0, 48);
    exp_b = expect_frame(48, 48);
    m_ready = 1'b0;
    got_q.delete(); got_cyc.delete();
    send_range(0, 47, 47);
    send_range(48, 95, 95);
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_hold_s_ready got=%b want=0", s_ready); end
    stable = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== exp_a) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin failures++; $display("FAIL bp_stable got=%h want=%h", m_data, exp_a); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready_late got=%b want=0", s_ready); end
    m_ready = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL bp_no_bubble got=%b want=1", m_valid); end
    checks++; if (m_data !== exp_b) begin failures++; $display("FAIL bp_frame2 got=%h want=%h", m_data, exp_b); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL bp_refill got=%b want=1", s_ready); end
    tick();
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", m_valid); end
    wait_frames(2);
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== exp_a) begin failures++; $display("FAIL bp_order0 got=%h want=%h", got_q[0], exp_a); end
      checks++; if (got_q[1] !== exp_b) begin failures++; $display("FAIL bp_order1 got=%h want=%h", got_q[1], exp_b); end
      checks++; if (got_cyc[1] - got_cyc[0] != 1) begin failures++; $display("FAIL bp_gap got=%0d want=1", got_cyc[1] - got_cyc[0]); end
    end
  endtask

  task automatic test_missing_last();
    fill_smp(2);
    m_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL ml_pre_err got=%b want=0", frame_err); end
    send_range(0, 47, -1);
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL ml_err got=%b want=1", frame_err); end
    send_range(48, 60, 60);
    wait_frames(2);
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== expect_frame(0, 48)) begin failures++; $display("FAIL ml_frame1 got=%h want=%h", got_q[0], expect_frame(0, 48)); end
      checks++; if (got_q[1] !== expect_frame(48, 13)) begin failures++; $display("FAIL ml_frame2 got=%h want=%h", got_q[1], expect_frame(48, 13)); end
    end
  endtask

  task automatic test_reset_midframe();
    fill_smp(3);
    m_ready = 1'b0;
    got_q.delete(); got_cyc.delete();
    send_range(0, 47, 47);
    send_range(48, 52, -1);
    checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL rm_pending got=%b want=1", m_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rm_m_valid got=%b want=0", m_valid); end
    checks++; if (m_data !== '0) begin failures++; $display("FAIL rm_m_data got=%h want=0", m_data); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rm_frame_err got=%b want=0", frame_err); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rm_s_ready got=%b want=1", s_ready); end
    tick();
    tick();
    rst = 1'b1;
    tick();
    fill_smp(4);
    m_ready = 1'b1;
    send_range(0, 47, 47);
    wait_frames(1);
    repeat (3) tick();
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rm_extra_frames got=%0d want=1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== expect_frame(0, 48)) begin failures++; $display("FAIL rm_clean got=%h want=%h", got_q[0], expect_frame(0, 48)); end
    end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL rm_clean_err got=%b want=0", frame_err); end
  endtask

  task automatic test_early_last();
    fill_smp(5);
    m_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    send_range(0, 9, 9);
    wait_frames(1);
    if (got_q.size() == 1) begin
      checks++; if (got_q[0] !== expect_frame(0, 10)) begin failures++; $display("FAIL el_data got=%h want=%h", got_q[0], expect_frame(0, 10)); end
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL el_err got=%b want=1", frame_err); end
    send_range(0, 47, 47);
    wait_frames(2);
    if (got_q.size() == 2) begin
      checks++; if (got_q[1] !== expect_frame(0, 48)) begin failures++; $display("FAIL el_clean got=%h want=%h", got_q[1], expect_frame(0, 48)); end
    end
    checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL el_sticky got=%b want=1", frame_err); end
  endtask

`ifdef HGCAL_PACKER_STATS_EN
  task automatic test_stats();
    rst = 1'b0;
    tick();
    checks++; if (frame_cnt !== 16'd0 || err_cnt !== 16'd0) begin failures++; $display("FAIL st_reset got=%0d/%0d want=0/0", frame_cnt, err_cnt); end
    rst = 1'b1;
    tick();
    fill_smp(6);
    m_ready = 1'b1;
    got_q.delete(); got_cyc.delete();
    for (int f = 0; f < 5; f++) begin
      if (f == 2) send_range(0, 4, 4);
      else        send_range(0, 47, 47);
    end
    wait_frames(5);
    tick();
    checks++; if (frame_cnt !== 16'd5) begin failures++; $display("FAIL st_frame_cnt got=%0d want=5", frame_cnt); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL st_err_cnt got=%0d want=1", err_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_missing_last();
    test_reset_midframe();
    test_early_last();
`ifdef HGCAL_PACKER_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
